// File: rtl/lfsr_pkg.sv
// Shared constants, FSM encoding and next-state function for the seeded 32-bit LFSR.
// lfsr_next is kept here so other blocks can step the same polynomial.
package lfsr_pkg;

  localparam int          LFSR_WIDTH = 32;
  // x^32 + x^22 + x^2 + x + 1 -> taps on bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } lfsr_state_e;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_comb.sv
// Fixed-length LFSR run: load seed, shift STEPS times, latch the final state and freeze.
// The result changes once per reset session; only rst can re-seed.
module lfsr_comb
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             done
);

  localparam int CW = $clog2(STEPS + 1);

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] current_state, current_state_d;
  logic [CW-1:0]    counter, counter_d;
  logic [WIDTH-1:0] lfsr_out_q, lfsr_out_d;
  logic             done_q, done_d;
  logic             feedback;
  logic [WIDTH-1:0] next_state;

  assign feedback   = ^(current_state & LFSR_TAPS);
  assign next_state = lfsr_next(current_state);

  always_comb begin
    fsm_d           = fsm_q;
    current_state_d = current_state;
    counter_d       = counter;
    lfsr_out_d      = lfsr_out_q;
    done_d          = done_q;
    unique case (fsm_q)
      ST_LOAD: begin
        // All-zero would lock the register up forever
        current_state_d = (seed == '0) ? LFSR_ZERO_SUB : seed;
        fsm_d           = ST_RUN;
      end
      ST_RUN: begin
        current_state_d = next_state;
        counter_d       = counter + 1'b1;
        if (counter == CW'(STEPS - 1)) begin
          lfsr_out_d = next_state;
          done_d     = 1'b1;
          fsm_d      = ST_DONE;
        end
      end
      ST_DONE: ;
      default: fsm_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= ST_LOAD;
      current_state <= '0;
      counter       <= '0;
      lfsr_out_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      current_state <= current_state_d;
      counter       <= counter_d;
      lfsr_out_q    <= lfsr_out_d;
      done_q        <= done_d;
    end
  end

  assign lfsr_out = lfsr_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lfsr_comb.sv
// Three LFSR instances (STEPS=4, 1, 32) driven through reset sessions with random and
// directed seeds, compared every edge against an arithmetic shift-register model.
module tb_lfsr_comb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seed4, seed1, seed32;
  logic [31:0] out4, out1, out32;
  logic        done4, done1, done32;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_comb #(.STEPS(4)) u4  (.clk(clk), .rst(rst), .seed(seed4),  .lfsr_out(out4),  .done(done4));
  lfsr_comb #(.STEPS(1)) u1  (.clk(clk), .rst(rst), .seed(seed1),  .lfsr_out(out1),  .done(done1));
  lfsr_comb              u32 (.clk(clk), .rst(rst), .seed(seed32), .lfsr_out(out32), .done(done32));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: treat the state as an integer, double it modulo 2^32 and add the
  // parity of bits 31, 21, 1, 0 as the new LSB.
  function automatic logic [31:0] m_fb(input logic [31:0] s);
    int ones = 0;
    if (s[31]) ones++;
    if (s[21]) ones++;
    if (s[1])  ones++;
    if (s[0])  ones++;
    return 32'(ones % 2);
  endfunction

  function automatic logic [31:0] m_state(input logic [31:0] sd, input int shifts);
    logic [31:0] s = (sd == 0) ? 32'd1 : sd;
    for (int i = 0; i < shifts; i++) s = s * 2 + m_fb(s);
    return s;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_out4"},  out4, 0);
    chk({tag, "_out1"},  out1, 0);
    chk({tag, "_out32"}, out32, 0);
    chk({tag, "_done"},  {29'd0, done4, done1, done32}, 0);
    chk({tag, "_cnt32"}, 32'(u32.counter), 0);
    chk({tag, "_cnt4"},  32'(u4.counter), 0);
    chk({tag, "_st32"},  u32.current_state, 0);
  endtask

  // One reset session. chg_edge: edge after which seeds are scrambled (0 = never).
  // rst_edge: edge after which rst is asserted asynchronously (0 = never).
  task automatic session(input logic [31:0] s4, input logic [31:0] s1, input logic [31:0] s32,
                         input int chg_edge, input int rst_edge);
    int          steps [3] = '{4, 1, 32};
    logic [31:0] sd    [3];
    logic [31:0] st, ex;
    sd[0] = s4; sd[1] = s1; sd[2] = s32;
    seed4 = s4; seed1 = s1; seed32 = s32;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == chg_edge) begin
        seed4 = $urandom; seed1 = $urandom; seed32 = $urandom;
      end
      for (int d = 0; d < 3; d++) begin
        logic [31:0] o_st, o_out, o_cnt, o_fb;
        logic        o_done;
        int          n = (e - 1 < steps[d]) ? e - 1 : steps[d];
        case (d)
          0: begin o_st = u4.current_state;  o_out = out4;  o_done = done4;
                   o_cnt = 32'(u4.counter);  o_fb = 32'(u4.feedback);  end
          1: begin o_st = u1.current_state;  o_out = out1;  o_done = done1;
                   o_cnt = 32'(u1.counter);  o_fb = 32'(u1.feedback);  end
          default: begin o_st = u32.current_state; o_out = out32; o_done = done32;
                   o_cnt = 32'(u32.counter); o_fb = 32'(u32.feedback); end
        endcase
        st = m_state(sd[d], n);
        ex = (e >= 1 + steps[d]) ? st : 32'd0;
        chk($sformatf("state_d%0d_e%0d", d, e), o_st, st);
        chk($sformatf("fb_d%0d_e%0d", d, e), o_fb, m_fb(st));
        chk($sformatf("cnt_d%0d_e%0d", d, e), o_cnt, 32'(n));
        chk($sformatf("done_d%0d_e%0d", d, e), 32'(o_done), 32'(e >= 1 + steps[d]));
        chk($sformatf("out_d%0d_e%0d", d, e), o_out, ex);
      end
      if (e == rst_edge) begin
        #2 rst = 1'b1;
        #1 chk_zero($sformatf("async_rst_e%0d", e));
        return;
      end
    end
  endtask

  initial begin
    seed4 = 0; seed1 = 0; seed32 = 0;
    #12;
    // Directed: known short sequences and the all-ones / zero-seed corners
    session(32'h1, 32'hFFFF_FFFF, 32'h1234_FADC, 0, 0);
    chk("dir_seed1_s4",   out4, 32'h0000_001B);
    chk("dir_ones_s1",    out1, 32'hFFFF_FFFE);
    session(32'h0, 32'h0, 32'h1234_FADC, 8, 0);
    chk("dir_seed0_s4",   out4, 32'h0000_001B);
    chk("dir_seed0_s1",   out1, 32'h0000_0003);
    // Reset mid-RUN and in DONE, then a clean restart with the same seed
    session(32'h1, $urandom, 32'h1234_FADC, 0, 20);
    session($urandom, $urandom, 32'h1234_FADC, 3, 38);
    session(32'h0, $urandom, 32'h1234_FADC, 0, 0);
    chk("restart_s32", out32, m_state(32'h1234_FADC, 32));
    for (int r = 0; r < 6; r++)
      session($urandom, $urandom, $urandom, (r % 2) ? $urandom_range(2, 30) : 0,
              (r == 4) ? $urandom_range(2, 30) : 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
